// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
// Assembles SOF/LEN/payload/CHK frames from a uart_rx byte stream, checks the
// length and XOR checksum, buffers the payload and replays good payloads on a
// valid/ready byte stream. Every outcome is reported with a one-cycle pulse.
module uart_rx_frame_parser #(
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 17360
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_pl_valid,
  output logic [7:0] o_pl_data,
  output logic       o_pl_last,
  input  logic       i_pl_ready,
  output logic       o_frame_ok,
  output logic       o_err_chk,
  output logic       o_err_len,
  output logic       o_err_timeout,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       chk_q, chk_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             frame_ok_q, frame_ok_d;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             err_tmo_q, err_tmo_d;
  logic             overrun_q, overrun_d;

  // Payload storage; contents survive reset since only written entries are read
  logic [7:0]       buf_q [MAX_LEN];
  logic             buf_we_s;
  logic [IDX_W-1:0] idx_inc_s;
  logic [IDX_W-1:0] rd_idx_inc_s;
  logic             rd_last_s;
  logic             mid_frame_s;

  assign idx_inc_s    = idx_q + IDX_W'(1);
  assign rd_idx_inc_s = rd_idx_q + IDX_W'(1);
  assign rd_last_s    = (8'(rd_idx_q) == (len_q - 8'd1));
  assign mid_frame_s  = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

  // Next-state, counter and pulse computation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    idx_d      = idx_q;
    rd_idx_d   = rd_idx_q;
    tmo_d      = tmo_q;
    frame_ok_d = 1'b0;
    err_chk_d  = 1'b0;
    err_len_d  = 1'b0;
    err_tmo_d  = 1'b0;
    overrun_d  = 1'b0;
    buf_we_s   = 1'b0;

    case (state_q)
      ST_HUNT: begin
        tmo_d = '0;
        if (i_rx_dv && (i_rx_byte == SOF_BYTE)) begin
          state_d = ST_LEN;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_LEN: begin
        if (i_rx_dv) begin
          tmo_d = '0;
          len_d = i_rx_byte;
          chk_d = i_rx_byte;
          if ((i_rx_byte == 8'd0) || (i_rx_byte > 8'(MAX_LEN))) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (i_rx_dv) begin
          tmo_d    = '0;
          buf_we_s = 1'b1;
          chk_d    = chk_q ^ i_rx_byte;
          idx_d    = idx_inc_s;
          if (8'(idx_inc_s) == len_q) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_CHK: begin
        if (i_rx_dv) begin
          tmo_d = '0;
          if (i_rx_byte == chk_q) begin
            frame_ok_d = 1'b1;
            rd_idx_d   = '0;
            state_d    = ST_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_DRAIN: begin
        tmo_d = '0;
        if (i_rx_dv) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = 1'b0;
        end
        if (i_pl_ready) begin
          if (rd_last_s) begin
            state_d = ST_HUNT;
          end else begin
            rd_idx_d = rd_idx_inc_s;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_HUNT;
        tmo_d   = '0;
      end
    endcase

    // Inter-byte watchdog: a strobe in the same cycle already cleared it above
    if (mid_frame_s && !i_rx_dv) begin
      if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
        err_tmo_d = 1'b1;
        tmo_d     = '0;
        state_d   = ST_HUNT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      err_tmo_d = 1'b0;
    end
  end

  // State, counters and pulse registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_HUNT;
      len_q      <= 8'd0;
      chk_q      <= 8'd0;
      idx_q      <= '0;
      rd_idx_q   <= '0;
      tmo_q      <= '0;
      frame_ok_q <= 1'b0;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
      rd_idx_q   <= rd_idx_d;
      tmo_q      <= tmo_d;
      frame_ok_q <= frame_ok_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_tmo_q  <= err_tmo_d;
      overrun_q  <= overrun_d;
    end
  end

  // Payload buffer write port
  always_ff @(posedge i_clk) begin
    if (buf_we_s) begin
      buf_q[idx_q[BUF_AW-1:0]] <= i_rx_byte;
    end
  end

  // Stream outputs come straight from state flops so reset clears them at once
  assign o_pl_valid    = (state_q == ST_DRAIN);
  assign o_pl_data     = o_pl_valid ? buf_q[rd_idx_q[BUF_AW-1:0]] : 8'd0;
  assign o_pl_last     = o_pl_valid && rd_last_s;
  assign o_busy        = (state_q != ST_HUNT);
  assign o_frame_ok    = frame_ok_q;
  assign o_err_chk     = err_chk_q;
  assign o_err_len     = err_len_q;
  assign o_err_timeout = err_tmo_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: drives the byte strobe directly.
module tb_uart_rx_frame_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       pl_ready = 1'b1;
  logic       pl_valid, pl_last, frame_ok, err_chk, err_len, err_tmo, overrun, busy;
  logic [7:0] pl_data;

  int cmps = 0;
  int errs = 0;
  int ok_cnt, chk_cnt, len_cnt, tmo_cnt, ovr_cnt, valid_cnt, stall_cnt;
  logic [8:0] outq [$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = 9'd0;

  uart_rx_frame_parser dut (
    .i_clk(clk), .i_rst(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
    .o_pl_valid(pl_valid), .o_pl_data(pl_data), .o_pl_last(pl_last),
    .i_pl_ready(pl_ready), .o_frame_ok(frame_ok), .o_err_chk(err_chk),
    .o_err_len(err_len), .o_err_timeout(err_tmo), .o_overrun(overrun), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: pulse counts, accepted payload bytes, stall stability
  always @(negedge clk) begin
    if (frame_ok) ok_cnt++;
    if (err_chk)  chk_cnt++;
    if (err_len)  len_cnt++;
    if (err_tmo)  tmo_cnt++;
    if (overrun)  ovr_cnt++;
    if (pl_valid) valid_cnt++;
    if (prev_stall && pl_valid) begin
      stall_cnt++;
      check("stall_hold", {23'd0, pl_last, pl_data}, {23'd0, prev_word});
    end
    if (pl_valid && pl_ready) outq.push_back({pl_last, pl_data});
    prev_stall = pl_valid && !pl_ready;
    prev_word  = {pl_last, pl_data};
  end

  task automatic clr();
    ok_cnt = 0; chk_cnt = 0; len_cnt = 0; tmo_cnt = 0; ovr_cnt = 0;
    valid_cnt = 0; stall_cnt = 0;
    outq.delete();
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_byte = 8'd0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && busy; n++) begin
      @(posedge clk); #1;
    end
    check("idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [8:0] e0, input logic [8:0] e1,
                           input logic [8:0] e2, input int n);
    logic [8:0] exp [3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    check({tag, "_count"}, outq.size(), n);
    for (int i = 0; i < n && i < outq.size(); i++) check({tag, "_byte"}, {23'd0, outq[i]}, {23'd0, exp[i]});
  endtask

  initial begin
    int n;
    clr();
    #1;
    check("rst_valid", {31'd0, pl_valid}, 32'd0);
    check("rst_outs", {24'd0, busy, frame_ok, err_chk, err_len, err_tmo, overrun, pl_last, 1'b0}, 32'd0);
    check("rst_data", {24'd0, pl_data}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: good frame with ready held high
    clr(); pl_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send(8'h03);
    check("t1_ok_pulse", {31'd0, frame_ok}, 32'd1);
    check("t1_first", {23'd0, pl_valid, pl_data}, {23'd1, 8'h11});
    wait_idle();
    check_out("t1_out", {1'b0, 8'h11}, {1'b0, 8'h22}, {1'b1, 8'h33}, 3);
    check("t1_ok_cnt", ok_cnt, 1);

    // 2: checksum mismatch
    clr();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    check("t2_errchk_pulse", {31'd0, err_chk}, 32'd1);
    @(posedge clk); #1;
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_valid_cnt", valid_cnt, 0);
    check("t2_ok_cnt", ok_cnt, 0);

    // 3: noise bytes and illegal lengths
    clr();
    send(8'h00); send(8'hFF);
    check("t3_noise_busy", {31'd0, busy}, 32'd0);
    send(8'hA5); send(8'h00);
    check("t3_len0_pulse", {31'd0, err_len}, 32'd1);
    send(8'hA5); send(8'h11);
    check("t3_len17_pulse", {31'd0, err_len}, 32'd1);
    @(posedge clk); #1;
    check("t3_len_cnt", len_cnt, 2);
    check("t3_other_errs", chk_cnt + tmo_cnt + ok_cnt, 0);

    // 4: inter-byte timeout then recovery
    clr();
    send(8'hA5); send(8'h02); send(8'h11);
    n = 0;
    while (!err_tmo && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_tmo_window", {31'd0, (n >= 17355 && n <= 17365)}, 32'd1);
    repeat (50) @(posedge clk);
    #1;
    check("t4_tmo_cnt", tmo_cnt, 1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    clr();
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    wait_idle();
    check_out("t4_out", {1'b1, 8'h7E}, 9'd0, 9'd0, 1);

    // 5: stalled consumer and a byte arriving during drain
    clr(); pl_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    for (int i = 0; i < 40 && busy; i++) begin
      pl_ready = ((i / 3) % 2) == 1;
      rx_dv    = (i == 4);
      rx_byte  = 8'h55;
      @(posedge clk); #1;
      rx_dv = 1'b0;
    end
    pl_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_ovr_cnt", ovr_cnt, 1);
    check("t5_stalled", {31'd0, stall_cnt > 0}, 32'd1);
    check_out("t5_out", {1'b0, 8'h11}, {1'b0, 8'h22}, {1'b1, 8'h33}, 3);

    // 6: reset in the middle of a payload
    clr();
    send(8'hA5); send(8'h03); send(8'h11);
    rst = 1'b1;
    #1;
    check("t6_rst_outs", {23'd0, busy, pl_valid, frame_ok, err_chk, err_len, err_tmo, overrun, pl_last, 1'b0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_no_pulses", ok_cnt + chk_cnt + len_cnt + tmo_cnt + ovr_cnt, 0);
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
    check("t6_ok_pulse", {31'd0, frame_ok}, 32'd1);
    wait_idle();
    check_out("t6_out", {1'b0, 8'h10}, {1'b1, 8'h20}, 9'd0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
